// File: rtl/fir_sample_controller.sv
// Control FSM for the FIR sample datapath: sequences coefficient loads, sample
// store, history shift and the 4-tap MAC, one register-file op per clock.
// Moore machine; every output is decoded from the current state only.
module fir_sample_controller #(
  parameter int OP_W    = 3,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               dr,
  input  logic               lc,
  input  logic               overflow,
  output logic               cnt_up,
  output logic               clear,
  output logic               modwait,
  output logic [OP_W-1:0]    op,
  output logic [RADDR_W-1:0] src1,
  output logic [RADDR_W-1:0] src2,
  output logic [RADDR_W-1:0] dest,
  output logic               err
);

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_COPY  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD1 = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOAD2 = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6);

  // Register map: R0 accumulator, R1..R4 history (R1 newest), R5 incoming
  // sample, R6 product temp, R7..R10 coefficients F0..F3.
  localparam logic [RADDR_W-1:0] R0  = RADDR_W'(0);
  localparam logic [RADDR_W-1:0] R1  = RADDR_W'(1);
  localparam logic [RADDR_W-1:0] R2  = RADDR_W'(2);
  localparam logic [RADDR_W-1:0] R3  = RADDR_W'(3);
  localparam logic [RADDR_W-1:0] R4  = RADDR_W'(4);
  localparam logic [RADDR_W-1:0] R5  = RADDR_W'(5);
  localparam logic [RADDR_W-1:0] R6  = RADDR_W'(6);
  localparam logic [RADDR_W-1:0] R7  = RADDR_W'(7);
  localparam logic [RADDR_W-1:0] R8  = RADDR_W'(8);
  localparam logic [RADDR_W-1:0] R9  = RADDR_W'(9);
  localparam logic [RADDR_W-1:0] R10 = RADDR_W'(10);

  typedef enum logic [4:0] {
    IDLE, STORE, SHIFT1, SHIFT2, SHIFT3, SHIFT4,
    MUL1, COPY1, MUL2, SUB1, MUL3, ADD1, MUL4, SUB2,
    EIDLE,
    LOAD_F0, WAIT_F1, LOAD_F1, WAIT_F2, LOAD_F2, WAIT_F3, LOAD_F3
  } state_t;

  state_t state_reg, state_next;

  // State register; reset aborts any sequence in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: dr wins over lc in IDLE/EIDLE; overflow only matters
  // on the edges leaving the accumulate steps.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, EIDLE: begin
        if (dr)      state_next = STORE;
        else if (lc) state_next = LOAD_F0;
      end
      STORE:   state_next = dr ? SHIFT1 : EIDLE;
      SHIFT1:  state_next = SHIFT2;
      SHIFT2:  state_next = SHIFT3;
      SHIFT3:  state_next = SHIFT4;
      SHIFT4:  state_next = MUL1;
      MUL1:    state_next = COPY1;
      COPY1:   state_next = MUL2;
      MUL2:    state_next = SUB1;
      SUB1:    state_next = overflow ? EIDLE : MUL3;
      MUL3:    state_next = ADD1;
      ADD1:    state_next = overflow ? EIDLE : MUL4;
      MUL4:    state_next = SUB2;
      SUB2:    state_next = overflow ? EIDLE : IDLE;
      LOAD_F0: state_next = WAIT_F1;
      WAIT_F1: if (lc) state_next = LOAD_F1;
      LOAD_F1: state_next = WAIT_F2;
      WAIT_F2: if (lc) state_next = LOAD_F2;
      LOAD_F2: state_next = WAIT_F3;
      WAIT_F3: if (lc) state_next = LOAD_F3;
      LOAD_F3: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: one datapath op per state, unused source fields held at 0.
  always_comb begin
    cnt_up  = 1'b0;
    clear   = 1'b0;
    modwait = 1'b1;
    err     = 1'b0;
    op      = OP_NOP;
    src1    = R0;
    src2    = R0;
    dest    = R0;
    unique case (state_reg)
      IDLE:    modwait = 1'b0;
      EIDLE:   begin modwait = 1'b0; err = 1'b1; end
      WAIT_F1, WAIT_F2, WAIT_F3: modwait = 1'b0;
      STORE:   begin op = OP_LOAD1; dest = R5; end
      SHIFT1:  begin op = OP_COPY; src1 = R3; dest = R4; cnt_up = 1'b1; end
      SHIFT2:  begin op = OP_COPY; src1 = R2; dest = R3; end
      SHIFT3:  begin op = OP_COPY; src1 = R1; dest = R2; end
      SHIFT4:  begin op = OP_COPY; src1 = R5; dest = R1; end
      MUL1:    begin op = OP_MUL;  src1 = R1; src2 = R7;  dest = R6; end
      COPY1:   begin op = OP_COPY; src1 = R6; dest = R0; end
      MUL2:    begin op = OP_MUL;  src1 = R2; src2 = R8;  dest = R6; end
      SUB1:    begin op = OP_SUB;  src1 = R0; src2 = R6;  dest = R0; end
      MUL3:    begin op = OP_MUL;  src1 = R3; src2 = R9;  dest = R6; end
      ADD1:    begin op = OP_ADD;  src1 = R0; src2 = R6;  dest = R0; end
      MUL4:    begin op = OP_MUL;  src1 = R4; src2 = R10; dest = R6; end
      SUB2:    begin op = OP_SUB;  src1 = R0; src2 = R6;  dest = R0; end
      LOAD_F0: begin op = OP_LOAD2; dest = R7; clear = 1'b1; end
      LOAD_F1: begin op = OP_LOAD2; dest = R8; end
      LOAD_F2: begin op = OP_LOAD2; dest = R9; end
      LOAD_F3: begin op = OP_LOAD2; dest = R10; end
      default: modwait = 1'b0;
    endcase
  end

endmodule
